// File: rtl/alu_issue_ctrl_if.sv
// alu_issue_ctrl_if: request/response handshakes plus the ALU-side bus of alu_issue_ctrl.
// master is the environment (control unit and ALU), slave is the issuer.
interface alu_issue_ctrl_if #(
    parameter int WIDTH = 32
);
    logic             opValid;
    logic             opReady;
    logic [3:0]       opCode;
    logic [WIDTH-1:0] opA;
    logic [WIDTH-1:0] opB;
    logic [WIDTH-1:0] registerA;
    logic [WIDTH-1:0] registerB;
    logic [12:0]      ALU_instruc;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] result_hi;
    logic             carryOut;
    logic             resValid;
    logic             resReady;
    logic [WIDTH-1:0] resLo;
    logic [WIDTH-1:0] resHi;
    logic             resCarry;
    logic             resErr;
    logic [WIDTH-1:0] hiReg;
    logic [WIDTH-1:0] loReg;
    modport master (
        output opValid, opCode, opA, opB, result, result_hi, carryOut, resReady,
        input  opReady, registerA, registerB, ALU_instruc, resValid, resLo, resHi,
               resCarry, resErr, hiReg, loReg
    );
    modport slave (
        input  opValid, opCode, opA, opB, result, result_hi, carryOut, resReady,
        output opReady, registerA, registerB, ALU_instruc, resValid, resLo, resHi,
               resCarry, resErr, hiReg, loReg
    );
endinterface

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: issues one decoded ALU operation at a time and returns its captured result.
// Define ALU_HILO_EN to keep persistent HI/LO registers updated by MUL/DIV.
module alu_issue_ctrl #(
    parameter int WIDTH   = 32,
    parameter int ALU_LAT = 1
) (
    input logic             clock,
    input logic             reset,
    alu_issue_ctrl_if.slave bus
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;
    logic [1:0]       r_state;
    logic [3:0]       r_cnt;
    logic [3:0]       r_op;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_lo;
    logic [WIDTH-1:0] r_hi;
    logic             r_carry;
    logic             r_err;
    logic             w_accept;
    logic             w_done;
    logic             w_illegal;
    assign w_accept  = r_state == S_IDLE && bus.opValid;
    assign w_done    = r_state == S_WAIT && r_cnt == 4'd0;
    assign w_illegal = bus.opCode > 4'd12;
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_op    <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_lo    <= '0;
            r_hi    <= '0;
            r_carry <= 1'b0;
            r_err   <= 1'b0;
        end else if (w_accept) begin
            r_a     <= bus.opA;
            r_b     <= bus.opB;
            r_op    <= bus.opCode;
            r_cnt   <= 4'(ALU_LAT - 1);
            r_err   <= w_illegal;
            r_state <= w_illegal ? S_RESP : S_WAIT;
            if (w_illegal) begin
                r_lo    <= '0;
                r_hi    <= '0;
                r_carry <= 1'b0;
            end
        end else if (r_state == S_WAIT) begin
            r_cnt <= r_cnt - 4'd1;
            if (w_done) begin
                r_lo    <= bus.result;
                r_hi    <= bus.result_hi;
                r_carry <= bus.carryOut;
                r_state <= S_RESP;
            end
        end else if (r_state == S_RESP && bus.resReady) begin
            r_state <= S_IDLE;
        end
    end
    // opReady is masked by reset so it reads 0 for the whole reset pulse
    assign bus.opReady     = r_state == S_IDLE && !reset;
    assign bus.resValid    = r_state == S_RESP;
    assign bus.ALU_instruc = r_state == S_WAIT ? 13'd1 << r_op : 13'd0;
    assign bus.registerA   = r_a;
    assign bus.registerB   = r_b;
    assign bus.resLo       = r_lo;
    assign bus.resHi       = r_hi;
    assign bus.resCarry    = r_carry;
    assign bus.resErr      = r_err;
`ifdef ALU_HILO_EN
    logic [WIDTH-1:0] r_hi_reg;
    logic [WIDTH-1:0] r_lo_reg;
    always_ff @(posedge clock) begin
        if (reset) begin
            r_hi_reg <= '0;
            r_lo_reg <= '0;
        end else if (w_done && (r_op == 4'd4 || r_op == 4'd5)) begin
            r_hi_reg <= bus.result_hi;
            r_lo_reg <= bus.result;
        end
    end
    assign bus.hiReg = r_hi_reg;
    assign bus.loReg = r_lo_reg;
`else
    assign bus.hiReg = '0;
    assign bus.loReg = '0;
`endif
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl: directed bench for alu_issue_ctrl with ALU_LAT=1 and ALU_LAT=4 instances
// driven by a behavioural ALU; expected responses are hand-computed constants.
module tb_alu_issue_ctrl;
`ifdef ALU_HILO_EN
    localparam bit HILO = 1'b1;
`else
    localparam bit HILO = 1'b0;
`endif
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    int          cyc = 0;
    int          total = 0;
    int          bad = 0;
    logic        op_valid [2];
    logic [3:0]  op_code [2];
    logic [31:0] op_a [2];
    logic [31:0] op_b [2];
    logic        res_ready [2];
    logic        op_ready [2];
    logic        res_valid [2];
    logic        res_err [2];
    logic        res_carry [2];
    logic [12:0] instr [2];
    logic [31:0] reg_a [2];
    logic [31:0] reg_b [2];
    logic [31:0] res_lo [2];
    logic [31:0] res_hi [2];
    logic [31:0] hi_reg [2];
    logic [31:0] lo_reg [2];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [64:0] alu_model(input logic [12:0] ins, input logic [31:0] a, input logic [31:0] b);
        logic [32:0] s;
        logic [63:0] p;
        logic [4:0]  n;
        logic [5:0]  m;
        s = {1'b0, a} + {1'b0, b};
        p = {32'd0, a} * {32'd0, b};
        n = b[4:0];
        m = 6'd32 - {1'b0, n};
        alu_model = '0;
        if (ins[0]) alu_model = {33'd0, a & b};
        if (ins[1]) alu_model = {33'd0, a | b};
        if (ins[2]) alu_model = {s[32], 32'd0, s[31:0]};
        if (ins[3]) alu_model = {33'd0, a - b};
        if (ins[4]) alu_model = {1'b0, p};
        if (ins[5] && b != 0) alu_model = {1'b0, a % b, a / b};
        if (ins[6]) alu_model = {33'd0, a >> n};
        if (ins[7]) alu_model = {33'd0, 32'($signed(a) >>> n)};
        if (ins[8]) alu_model = {33'd0, a << n};
        if (ins[9]) alu_model = {33'd0, (a >> n) | (a << m)};
        if (ins[10]) alu_model = {33'd0, (a << n) | (a >> m)};
        if (ins[11]) alu_model = {33'd0, -a};
        if (ins[12]) alu_model = {33'd0, ~a};
    endfunction

    for (genvar g = 0; g < 2; g++) begin : gi
        alu_issue_ctrl_if #(.WIDTH(32)) bus ();
        alu_issue_ctrl #(.WIDTH(32), .ALU_LAT(g == 0 ? 1 : 4)) dut (
            .clock(clk),
            .reset(rst),
            .bus  (bus)
        );
        assign bus.opValid  = op_valid[g];
        assign bus.opCode   = op_code[g];
        assign bus.opA      = op_a[g];
        assign bus.opB      = op_b[g];
        assign bus.resReady = res_ready[g];
        assign {bus.carryOut, bus.result_hi, bus.result} = alu_model(bus.ALU_instruc, bus.registerA, bus.registerB);
        assign op_ready[g]  = bus.opReady;
        assign res_valid[g] = bus.resValid;
        assign res_err[g]   = bus.resErr;
        assign res_carry[g] = bus.resCarry;
        assign instr[g]     = bus.ALU_instruc;
        assign reg_a[g]     = bus.registerA;
        assign reg_b[g]     = bus.registerB;
        assign res_lo[g]    = bus.resLo;
        assign res_hi[g]    = bus.resHi;
        assign hi_reg[g]    = bus.hiReg;
        assign lo_reg[g]    = bus.loReg;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // issue one op and follow it until resValid; lat counts cycles from the accept edge
    task automatic run_op(input int k, input logic [3:0] code, input logic [31:0] a, input logic [31:0] b,
                          output int lat, output int hot, output logic [12:0] seen, output int acc);
        int w = 0;
        op_valid[k] = 1'b1;
        op_code[k]  = code;
        op_a[k]     = a;
        op_b[k]     = b;
        while (!op_ready[k] && w < 20) begin
            step();
            w++;
        end
        step();
        acc = cyc;
        op_valid[k] = 1'b0;
        lat = -1;
        hot = 0;
        seen = '0;
        for (int n = 1; n <= 40; n++) begin
            if (instr[k] != 13'd0) hot++;
            seen |= instr[k];
            if (res_valid[k]) begin
                lat = n;
                break;
            end
            step();
        end
    endtask

    task automatic ack(input int k);
        res_ready[k] = 1'b1;
        step();
        res_ready[k] = 1'b0;
        chk("ack_ready", 64'(op_ready[k]), 64'd1);
        chk("ack_valid", 64'(res_valid[k]), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        int lat, hot, acc, acc1, nv;
        logic [12:0] seen;
        for (int k = 0; k < 2; k++) begin
            op_valid[k] = 1'b0;
            op_code[k] = '0;
            op_a[k] = '0;
            op_b[k] = '0;
            res_ready[k] = 1'b0;
        end
        step();
        step();
        for (int k = 0; k < 2; k++) begin
            chk("rst_ctl", {op_ready[k], res_valid[k], res_err[k], res_carry[k], instr[k]}, 64'd0);
            chk("rst_res", {res_hi[k], res_lo[k]}, 64'd0);
        end
        rst = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) chk("rel_ready", 64'(op_ready[k]), 64'd1);

        // reset in the middle of WAIT on the ALU_LAT=4 instance
        run_op(1, 4'd2, 32'd3, 32'd4, lat, hot, seen, acc);
        chk("pre_add_lo", 64'(res_lo[1]), 64'd7);
        ack(1);
        op_valid[1] = 1'b1;
        op_code[1] = 4'd2;
        op_a[1] = 32'd5;
        op_b[1] = 32'd6;
        step();
        op_valid[1] = 1'b0;
        step();
        chk("mid_wait_instr", 64'(instr[1]), 64'h4);
        rst = 1'b1;
        step();
        chk("mrst_ctl", {op_ready[1], res_valid[1], res_err[1], res_carry[1], instr[1]}, 64'd0);
        chk("mrst_regab", {reg_a[1], reg_b[1]}, 64'd0);
        chk("mrst_res", {res_hi[1], res_lo[1]}, 64'd0);
        chk("mrst_hilo", {hi_reg[1], lo_reg[1]}, 64'd0);
        rst = 1'b0;
        #1;
        chk("mrst_ready", 64'(op_ready[1]), 64'd1);
        nv = 0;
        repeat (8) begin
            step();
            if (res_valid[1]) nv++;
        end
        chk("mrst_no_resp", 64'(nv), 64'd0);

        // ADD with carry, ALU_LAT=1
        run_op(0, 4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, hot, seen, acc);
        chk("add_instr", 64'(seen), 64'h4);
        chk("add_hot", 64'(hot), 64'd1);
        chk("add_lat", 64'(lat), 64'd2);
        chk("add_lo", 64'(res_lo[0]), 64'hFFFF_FFFE);
        chk("add_carry", 64'(res_carry[0]), 64'd1);
        chk("add_err", 64'(res_err[0]), 64'd0);
        ack(0);

        // ROL then backpressure with a competing request
        run_op(0, 4'd10, 32'h8000_0001, 32'h0000_000A, lat, hot, seen, acc);
        chk("rol_instr", 64'(seen), 64'h400);
        chk("rol_lo", 64'(res_lo[0]), 64'h600);
        op_valid[0] = 1'b1;
        op_code[0] = 4'd2;
        op_a[0] = 32'hDEAD_BEEF;
        nv = 0;
        repeat (5) begin
            step();
            if (!res_valid[0] || res_lo[0] != 32'h600 || op_ready[0] || reg_a[0] != 32'h8000_0001) nv++;
        end
        chk("rol_hold", 64'(nv), 64'd0);
        op_valid[0] = 1'b0;
        ack(0);

        // MUL, AND, DIV and the HI/LO registers
        run_op(0, 4'd4, 32'h0001_0000, 32'h0001_0000, lat, hot, seen, acc);
        chk("mul_res", {res_hi[0], res_lo[0]}, 64'h1_0000_0000);
        chk("mul_hilo", {hi_reg[0], lo_reg[0]}, HILO ? 64'h1_0000_0000 : 64'd0);
        ack(0);
        run_op(0, 4'd0, 32'hF0, 32'h3C, lat, hot, seen, acc);
        chk("and_lo", 64'(res_lo[0]), 64'h30);
        chk("and_hilo", {hi_reg[0], lo_reg[0]}, HILO ? 64'h1_0000_0000 : 64'd0);
        ack(0);
        run_op(0, 4'd5, 32'd100, 32'd7, lat, hot, seen, acc);
        chk("div_res", {res_hi[0], res_lo[0]}, {32'd2, 32'd14});
        chk("div_hilo", {hi_reg[0], lo_reg[0]}, HILO ? {32'd2, 32'd14} : 64'd0);
        ack(0);

        // illegal opcode, then the next accept clears resErr
        run_op(0, 4'd14, 32'h1234, 32'h5678, lat, hot, seen, acc);
        chk("ill_lat", 64'(lat), 64'd1);
        chk("ill_instr", 64'(seen), 64'd0);
        chk("ill_err", 64'(res_err[0]), 64'd1);
        chk("ill_res", {res_hi[0], res_lo[0]}, 64'd0);
        chk("ill_carry", 64'(res_carry[0]), 64'd0);
        ack(0);
        run_op(0, 4'd2, 32'd1, 32'd1, lat, hot, seen, acc);
        chk("clr_err", 64'(res_err[0]), 64'd0);
        chk("clr_lo", 64'(res_lo[0]), 64'd2);
        ack(0);

        // back-to-back on ALU_LAT=4 with resReady held high
        res_ready[1] = 1'b1;
        run_op(1, 4'd3, 32'hA, 32'hF, lat, hot, seen, acc1);
        chk("sub_lo", 64'(res_lo[1]), 64'hFFFF_FFFB);
        chk("sub_hot", 64'(hot), 64'd4);
        chk("sub_lat", 64'(lat), 64'd5);
        chk("sub_instr", 64'(seen), 64'h8);
        run_op(1, 4'd1, 32'h0F, 32'hF0, lat, hot, seen, acc);
        chk("or_lo", 64'(res_lo[1]), 64'hFF);
        chk("or_hot", 64'(hot), 64'd4);
        chk("or_lat", 64'(lat), 64'd5);
        chk("b2b_gap", 64'(acc - acc1), 64'd6);
        step();
        res_ready[1] = 1'b0;
        chk("b2b_idle", 64'(op_ready[1]), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
